// File: rtl/fcpu_pkg.sv
// Shared constants and FSM state types for the global-memory AXI responder.
package fcpu_pkg;
    localparam int DATA_W      = 32;
    localparam int GMEM_N_BANK = 4;
    localparam int GMEM_ADDR_W = 32;
    localparam int ID_WIDTH    = 6;
    localparam int BURST_W     = 8;

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
endpackage

// File: rtl/gmem_bram_1r1w.sv
// Simple dual-port RAM: byte-enable write port, registered read port with
// read enable. A same-address read and write returns the old contents.
module gmem_bram_1r1w #(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 128
) (
    input  logic                  clk,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Byte-masked write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
    end

    // Registered read; output holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/gmem_axi_responder.sv
// AXI4 INCR-burst slave backed by on-chip RAM. Independent read and write
// engines; each beat is one full RAM line.
import fcpu_pkg::*;

module gmem_axi_responder #(
    parameter int GMEM_ADDR_W = fcpu_pkg::GMEM_ADDR_W,
    parameter int DATA_W      = fcpu_pkg::DATA_W,
    parameter int GMEM_N_BANK = fcpu_pkg::GMEM_N_BANK,
    parameter int ID_WIDTH    = fcpu_pkg::ID_WIDTH,
    parameter int MEM_LINES_W = 12
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [GMEM_ADDR_W-1:0]          axi_araddr,
    input  logic [BURST_W-1:0]              axi_arlen,
    input  logic                            axi_arvalid,
    output logic                            axi_arready,
    input  logic [ID_WIDTH-1:0]             axi_arid,
    output logic [DATA_W*GMEM_N_BANK-1:0]   axi_rdata,
    output logic                            axi_rlast,
    output logic                            axi_rvalid,
    input  logic                            axi_rready,
    output logic [ID_WIDTH-1:0]             axi_rid,
    input  logic [GMEM_ADDR_W-1:0]          axi_awaddr,
    input  logic [BURST_W-1:0]              axi_awlen,
    input  logic                            axi_awvalid,
    output logic                            axi_awready,
    input  logic [ID_WIDTH-1:0]             axi_awid,
    input  logic [DATA_W*GMEM_N_BANK-1:0]   axi_wdata,
    input  logic [DATA_W*GMEM_N_BANK/8-1:0] axi_wstrb,
    input  logic                            axi_wlast,
    input  logic                            axi_wvalid,
    output logic                            axi_wready,
    output logic                            axi_bvalid,
    input  logic                            axi_bready,
    output logic [ID_WIDTH-1:0]             axi_bid,
    output logic                            protocol_err
);
    localparam int BEAT_W = DATA_W * GMEM_N_BANK;
    localparam int STRB_W = BEAT_W / 8;
    localparam int OFS_W  = $clog2(STRB_W);

    // Line index: drop sub-beat bits, wrap to RAM depth.
    logic [MEM_LINES_W-1:0] ar_idx, aw_idx;
    assign ar_idx = MEM_LINES_W'(axi_araddr >> OFS_W);
    assign aw_idx = MEM_LINES_W'(axi_awaddr >> OFS_W);

    // ---------------- read engine ----------------
    r_state_t               r_state;
    logic [MEM_LINES_W-1:0] r_ptr;
    logic [BURST_W-1:0]     r_len, r_cnt;
    logic                   rd_en;
    logic [MEM_LINES_W-1:0] rd_addr;
    logic [BEAT_W-1:0]      rd_q;
    logic                   ar_hs, r_hs;

    assign ar_hs = axi_arvalid && axi_arready;
    assign r_hs  = axi_rvalid && axi_rready;

    // Fetch first line on AR, next line only when the current beat is taken.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = r_ptr + MEM_LINES_W'(1);
        if (ar_hs) begin
            rd_en   = 1'b1;
            rd_addr = ar_idx;
        end else if (r_hs && !axi_rlast) begin
            rd_en   = 1'b1;
        end
    end

    // Read burst FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= R_IDLE;
            axi_arready <= 1'b1;
            axi_rvalid  <= 1'b0;
            axi_rlast   <= 1'b0;
            axi_rid     <= '0;
            r_ptr       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (axi_arvalid) begin
                    r_state     <= R_BURST;
                    axi_arready <= 1'b0;
                    axi_rvalid  <= 1'b1;
                    axi_rlast   <= (axi_arlen == '0);
                    axi_rid     <= axi_arid;
                    r_ptr       <= ar_idx;
                    r_len       <= axi_arlen;
                    r_cnt       <= '0;
                end
                R_BURST: if (axi_rready) begin
                    if (axi_rlast) begin
                        r_state     <= R_IDLE;
                        axi_arready <= 1'b1;
                        axi_rvalid  <= 1'b0;
                        axi_rlast   <= 1'b0;
                    end else begin
                        r_ptr     <= r_ptr + MEM_LINES_W'(1);
                        r_cnt     <= r_cnt + BURST_W'(1);
                        axi_rlast <= ((r_cnt + BURST_W'(1)) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // RAM output is not reset, so present zero whenever no beat is valid.
    assign axi_rdata = axi_rvalid ? rd_q : '0;

    // ---------------- write engine ----------------
    w_state_t               w_state;
    logic [MEM_LINES_W-1:0] w_ptr;
    logic [BURST_W-1:0]     w_len, w_cnt;
    logic                   w_hs, w_end;
    logic [STRB_W-1:0]      wr_be;

    assign w_hs  = axi_wvalid && axi_wready;
    assign w_end = (w_cnt == w_len);
    assign wr_be = w_hs ? axi_wstrb : '0;

    // Write burst FSM; burst length is taken from awlen, wlast is only audited.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            w_state      <= W_IDLE;
            axi_awready  <= 1'b1;
            axi_wready   <= 1'b0;
            axi_bvalid   <= 1'b0;
            axi_bid      <= '0;
            protocol_err <= 1'b0;
            w_ptr        <= '0;
            w_len        <= '0;
            w_cnt        <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (axi_awvalid) begin
                    w_state     <= W_DATA;
                    axi_awready <= 1'b0;
                    axi_wready  <= 1'b1;
                    axi_bid     <= axi_awid;
                    w_ptr       <= aw_idx;
                    w_len       <= axi_awlen;
                    w_cnt       <= '0;
                end
                W_DATA: if (axi_wvalid) begin
                    w_ptr <= w_ptr + MEM_LINES_W'(1);
                    w_cnt <= w_cnt + BURST_W'(1);
                    if (axi_wlast != w_end) protocol_err <= 1'b1;
                    if (w_end) begin
                        w_state    <= W_RESP;
                        axi_wready <= 1'b0;
                        axi_bvalid <= 1'b1;
                    end
                end
                W_RESP: if (axi_bready) begin
                    w_state     <= W_IDLE;
                    axi_bvalid  <= 1'b0;
                    axi_awready <= 1'b1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    gmem_bram_1r1w #(.ADDR_W(MEM_LINES_W), .WIDTH(BEAT_W)) u_ram (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_addr (w_ptr),
        .wr_data (axi_wdata),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_q)
    );
endmodule

// File: tb/tb_gmem_axi_responder.sv
// Scoreboard bench: stimulus pushes expected beats/responses from a line-array
// memory model; a negedge monitor pops and compares whatever the DUT presents.
module tb_gmem_axi_responder;
    localparam int BW    = 128;
    localparam int SW    = 16;
    localparam int DEPTH = 4096;

    logic            clk = 1'b0;
    logic            nrst;
    logic [31:0]     araddr, awaddr;
    logic [7:0]      arlen, awlen;
    logic            arvalid, arready, awvalid, awready;
    logic [5:0]      arid, awid, rid, bid;
    logic [BW-1:0]   rdata, wdata;
    logic [SW-1:0]   wstrb;
    logic            rlast, rvalid, rready, wlast, wvalid, wready;
    logic            bvalid, bready, perr;

    gmem_axi_responder dut (
        .clk(clk), .nrst(nrst),
        .axi_araddr(araddr), .axi_arlen(arlen), .axi_arvalid(arvalid),
        .axi_arready(arready), .axi_arid(arid),
        .axi_rdata(rdata), .axi_rlast(rlast), .axi_rvalid(rvalid),
        .axi_rready(rready), .axi_rid(rid),
        .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awvalid(awvalid),
        .axi_awready(awready), .axi_awid(awid),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
        .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bid(bid),
        .protocol_err(perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        logic [5:0]    id;
        logic          last;
    } rexp_t;

    rexp_t         rq[$];
    logic [5:0]    bq[$];
    logic [BW-1:0] mem_m [DEPTH];
    logic [BW-1:0] wbuf [256];
    logic [SW-1:0] sbuf [256];
    logic [BW-1:0] last_rdata;
    logic          perr_exp;
    int            nchk = 0;
    int            nerr = 0;
    int            rbeats = 0;
    int            rmode = 0;
    int            rcyc = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // rready/bready pattern: 0 = always, 1 = 1-0-0-1 repeating, 2 = random.
    always @(posedge clk) begin
        #1;
        rcyc++;
        case (rmode)
            0: begin rready = 1'b1; bready = 1'b1; end
            1: begin rready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3); bready = 1'b1; end
            default: begin
                rready = 1'($urandom_range(0, 1));
                bready = 1'($urandom_range(0, 1));
            end
        endcase
    end

    // Monitor: R beats, stall stability, B responses.
    logic          stall_v = 1'b0;
    logic [BW-1:0] h_data;
    logic          h_last;
    logic [5:0]    h_id;
    always @(negedge clk) begin
        rexp_t e;
        if (!nrst) begin
            stall_v = 1'b0;
        end else begin
            if (rvalid) begin
                if (stall_v) begin
                    chk("r_hold_data", rdata, h_data);
                    chk("r_hold_last", BW'(rlast), BW'(h_last));
                    chk("r_hold_id", BW'(rid), BW'(h_id));
                end
                if (rready) begin
                    if (rq.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL r_extra: unexpected beat %h", rdata);
                    end else begin
                        e = rq.pop_front();
                        chk("rdata", rdata, e.data);
                        chk("rid", BW'(rid), BW'(e.id));
                        chk("rlast", BW'(rlast), BW'(e.last));
                    end
                    last_rdata = rdata;
                    rbeats++;
                    stall_v = 1'b0;
                end else begin
                    stall_v = 1'b1;
                    h_data  = rdata;
                    h_last  = rlast;
                    h_id    = rid;
                end
            end else begin
                stall_v = 1'b0;
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL b_extra: unexpected response bid %h", bid);
                end else begin
                    chk("bid", BW'(bid), BW'(bq.pop_front()));
                end
            end
        end
    end

    // Write burst from wbuf/sbuf; bad_last>=0 puts wlast on that beat only.
    task automatic write_burst(input logic [31:0] addr, input int len, input logic [5:0] id,
                               input int bad_last);
        int idx, to;
        idx = int'(addr[15:4]);
        bq.push_back(id);
        @(posedge clk); #1;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len); awid = id;
        to = 0;
        do begin @(negedge clk); to++; end while (!awready && to < 50);
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            wvalid = 1'b1; wdata = wbuf[k]; wstrb = sbuf[k];
            wlast = (bad_last >= 0) ? (k == bad_last) : (k == len);
            if (wlast != (k == len)) perr_exp = 1'b1;
            to = 0;
            do begin @(negedge clk); to++; end while (!wready && to < 50);
            if (!wready) timeout("w_beat");
            for (int b = 0; b < SW; b++)
                if (sbuf[k][b]) mem_m[(idx + k) % DEPTH][b*8 +: 8] = wbuf[k][b*8 +: 8];
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        to = 0;
        while (bq.size() != 0 && to < 100) begin @(posedge clk); to++; end
        if (bq.size() != 0) begin timeout("b_resp"); bq.delete(); end
    endtask

    task automatic issue_ar(input logic [31:0] addr, input int len, input logic [5:0] id);
        int idx, to;
        rexp_t e;
        idx = int'(addr[15:4]);
        for (int k = 0; k <= len; k++) begin
            e.data = mem_m[(idx + k) % DEPTH];
            e.id   = id;
            e.last = (k == len);
            rq.push_back(e);
        end
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len); arid = id;
        to = 0;
        do begin @(negedge clk); to++; end while (!arready && to < 50);
        if (!arready) timeout("ar_handshake");
        chk("r_not_early", BW'(rvalid), BW'(0));
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("r_first_lat", BW'(rvalid), BW'(1));
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input logic [5:0] id);
        int to, base;
        base = rbeats;
        issue_ar(addr, len, id);
        to = 0;
        while (rq.size() != 0 && to < 600) begin @(posedge clk); to++; end
        if (rq.size() != 0) begin timeout("r_drain"); rq.delete(); end
        @(negedge clk);
        chk("r_count", BW'(rbeats - base), BW'(len + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, to;
        logic [31:0] a;
        int len;
        nrst = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        araddr = '0; awaddr = '0; arlen = '0; awlen = '0; arid = '0; awid = '0;
        wdata = '0; wstrb = '0; rready = 1'b1; bready = 1'b1; perr_exp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", BW'(arready), BW'(1));
        chk("rst_awready", BW'(awready), BW'(1));
        chk("rst_rvalid", BW'(rvalid), BW'(0));
        chk("rst_rlast", BW'(rlast), BW'(0));
        chk("rst_wready", BW'(wready), BW'(0));
        chk("rst_bvalid", BW'(bvalid), BW'(0));
        chk("rst_perr", BW'(perr), BW'(0));
        chk("rst_ids", BW'({rid, bid}), BW'(0));
        chk("rst_rdata", rdata, '0);
        @(posedge clk); #1 nrst = 1'b1;

        // 1: 8-beat write then readback
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = {4{32'(k) * 32'h11111111}};
            sbuf[k] = '1;
        end
        write_burst(32'h1000, 7, 6'd5, -1);
        read_burst(32'h1000, 7, 6'd3);

        // 2: stalled read
        rmode = 1;
        read_burst(32'h1000, 7, 6'd9);
        rmode = 0;

        // 3: partial strobe over an all-ones line
        wbuf[0] = '1; sbuf[0] = '1;
        write_burst(32'h400, 0, 6'd1, -1);
        wbuf[0] = {4{32'hcafecafe}}; sbuf[0] = 16'h000F;
        write_burst(32'h400, 0, 6'd2, -1);
        read_burst(32'h408, 0, 6'd4);
        chk("t3_merge", last_rdata, {{96{1'b1}}, 32'hcafecafe});

        // 4: burst wrapping from the last line to line 0
        wbuf[0] = {$urandom, $urandom, $urandom, $urandom}; sbuf[0] = '1;
        wbuf[1] = {$urandom, $urandom, $urandom, $urandom}; sbuf[1] = '1;
        write_burst(32'hFFF0, 1, 6'd6, -1);
        read_burst(32'h0, 0, 6'd7);
        chk("t4_line0", last_rdata, wbuf[1]);
        read_burst(32'hFFF0, 1, 6'd8);
        chk("perr_clean", BW'(perr), BW'(perr_exp));

        // 5: early wlast, termination follows awlen
        for (int k = 0; k < 4; k++) begin wbuf[k] = {4{$urandom}}; sbuf[k] = '1; end
        write_burst(32'h2000, 3, 6'd7, 1);
        chk("perr_set", BW'(perr), BW'(perr_exp));
        write_burst(32'h2100, 0, 6'd10, -1);
        chk("perr_sticky", BW'(perr), BW'(1));
        read_burst(32'h2000, 3, 6'd11);

        // concurrent read and write on different lines
        for (int k = 0; k < 4; k++) begin wbuf[k] = {$urandom, $urandom, $urandom, $urandom}; sbuf[k] = '1; end
        fork
            write_burst(32'h3000, 3, 6'd12, -1);
            read_burst(32'h1000, 7, 6'd13);
        join

        // random traffic
        rmode = 2;
        for (int it = 0; it < 10; it++) begin
            a = {16'h0, 12'($urandom), 4'($urandom)};
            len = $urandom_range(0, 15);
            for (int k = 0; k <= len; k++) begin
                wbuf[k] = {$urandom, $urandom, $urandom, $urandom};
                sbuf[k] = ($urandom_range(0, 2) == 0) ? '1 : 16'($urandom);
            end
            write_burst(a, len, 6'($urandom), -1);
            read_burst(a, $urandom_range(0, len), 6'($urandom));
        end
        rmode = 0;

        // 6: reset during a read burst
        base = rbeats;
        issue_ar(32'h1000, 7, 6'd20);
        to = 0;
        while (rbeats < base + 3 && to < 50) begin @(negedge clk); to++; end
        if (rbeats < base + 3) timeout("t6_beats");
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("t6_rvalid", BW'(rvalid), BW'(0));
        chk("t6_arready", BW'(arready), BW'(1));
        chk("t6_perr", BW'(perr), BW'(0));
        rq.delete();
        perr_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        read_burst(32'h1000, 7, 6'd21);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
